// File: rtl/csr_timer_int_pkg.sv
// Shared CSR addresses, field positions, writable-bit masks and timer state
// encoding for the csr_timer_int block.
package csr_timer_int_pkg;

  localparam logic [13:0] CSR_CRMD      = 14'h000;
  localparam logic [13:0] CSR_PRMD      = 14'h001;
  localparam logic [13:0] CSR_ECFG      = 14'h004;
  localparam logic [13:0] CSR_ESTAT     = 14'h005;
  localparam logic [13:0] CSR_ERA       = 14'h006;
  localparam logic [13:0] CSR_BADV      = 14'h007;
  localparam logic [13:0] CSR_EENTRY    = 14'h00c;
  localparam logic [13:0] CSR_SAVE_BASE = 14'h030;
  localparam logic [13:0] CSR_TID       = 14'h040;
  localparam logic [13:0] CSR_TCFG      = 14'h041;
  localparam logic [13:0] CSR_TVAL      = 14'h042;
  localparam logic [13:0] CSR_TICLR     = 14'h044;

  // Software-writable bits; every other bit is read-only or hardware-owned.
  localparam logic [31:0] CRMD_RW   = 32'h0000_001f;
  localparam logic [31:0] PRMD_RW   = 32'h0000_0007;
  localparam logic [31:0] ECFG_RW   = 32'h0000_1bff;
  localparam logic [31:0] ESTAT_RW  = 32'h0000_0003;
  localparam logic [31:0] EENTRY_RW = 32'hffff_ffc0;

  localparam logic [31:0] CRMD_RESET = 32'h0000_0008;

  localparam int CRMD_IE         = 2;
  localparam int IS_RSVD         = 10;
  localparam int IS_TIMER        = 11;
  localparam int IS_IPI          = 12;
  localparam int ESTAT_ECODE_LSB = 16;
  localparam int ESTAT_ESUB_LSB  = 22;
  localparam int TCFG_EN         = 0;
  localparam int TCFG_PERIODIC   = 1;

  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_e;

  function automatic logic [31:0] csr_merge(input logic [31:0] old_v,
                                            input logic [31:0] mask,
                                            input logic [31:0] val);
    return (mask & val) | (~mask & old_v);
  endfunction

  function automatic logic [31:0] csr_apply(input logic [31:0] old_v,
                                            input logic [31:0] mask,
                                            input logic [31:0] val,
                                            input logic [31:0] rw);
    return (csr_merge(old_v, mask, val) & rw) | (old_v & ~rw);
  endfunction

endpackage

// File: rtl/csr_timer_int_timer.sv
// Countdown timer: holds TCFG, runs an IDLE/RUN FSM over the counter and
// produces a one-cycle fire pulse while RUN sees the counter at zero.
module csr_timer_int_timer
  import csr_timer_int_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               tcfg_we_i,
  input  logic [TIMER_W-1:0] tcfg_wdata_i,
  output logic [TIMER_W-1:0] tcfg_o,
  output logic [31:0]        tval_o,
  output logic               fire_o
);

  tmr_state_e         state_q, state_d;
  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= TMR_IDLE;
      tcfg_q  <= '0;
      cnt_q   <= '1;
    end else begin
      state_q <= state_d;
      tcfg_q  <= tcfg_d;
      cnt_q   <= cnt_d;
    end
  end

  // A TCFG write always wins over the running count, including on a zero cycle.
  always_comb begin
    state_d = state_q;
    tcfg_d  = tcfg_q;
    cnt_d   = cnt_q;
    if (tcfg_we_i) begin
      tcfg_d = tcfg_wdata_i;
      if (tcfg_wdata_i[TCFG_EN]) begin
        cnt_d   = {tcfg_wdata_i[TIMER_W-1:2], 2'b00};
        state_d = TMR_RUN;
      end else begin
        state_d = TMR_IDLE;
      end
    end else if (state_q == TMR_RUN) begin
      if (!cnt_zero) begin
        cnt_d = cnt_q - TIMER_W'(1);
      end else if (tcfg_q[TCFG_PERIODIC]) begin
        cnt_d = {tcfg_q[TIMER_W-1:2], 2'b00};
      end else begin
        cnt_d   = '1;
        state_d = TMR_IDLE;
      end
    end
  end

  always_comb begin
    fire_o                 = (state_q == TMR_RUN) && cnt_zero;
    tcfg_o                 = tcfg_q;
    tval_o                 = '0;
    tval_o[TIMER_W-1:0]    = cnt_q;
  end

endmodule

// File: rtl/csr_timer_int.sv
// LoongArch CSR file: exception entry/return state, interrupt sampling,
// SAVE scratch registers, countdown timer and a registered interrupt request.
module csr_timer_int
  import csr_timer_int_pkg::*;
#(
  parameter int          TIMER_W    = 32,
  parameter int          HW_INT_NUM = 8,
  parameter int          SAVE_NUM   = 4,
  parameter logic [31:0] CORE_ID    = 32'h0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  csr_we,
  input  logic [13:0]           csr_num,
  input  logic [31:0]           csr_wmask,
  input  logic [31:0]           csr_wvalue,
  input  logic [13:0]           csr_raddr,
  output logic [31:0]           csr_rvalue,
  output logic [31:0]           ex_entry,
  output logic [31:0]           ex_exit,
  output logic                  has_int,
  input  logic                  ertn_flush,
  input  logic                  wb_ex,
  input  logic [5:0]            wb_ecode,
  input  logic [8:0]            wb_esubcode,
  input  logic [31:0]           wb_pc,
  input  logic [31:0]           wb_vaddr,
  input  logic [HW_INT_NUM-1:0] hw_int_in,
  input  logic                  ipi_int_in
);

  logic [31:0] crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d, estat_q, estat_d;
  logic [31:0] era_q, era_d, badv_q, badv_d, eentry_q, eentry_d, tid_q, tid_d;
  logic [31:0] save_q [SAVE_NUM];
  logic [31:0] save_d [SAVE_NUM];
  logic        has_int_q, has_int_d;

  logic [TIMER_W-1:0] tcfg_q;
  logic [31:0]        tcfg_rd, tval;
  logic               timer_fire, tcfg_we, ticlr_clr;
  logic [7:0]         hw_ext;

  assign tcfg_we   = csr_we && (csr_num == CSR_TCFG);
  assign ticlr_clr = csr_we && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];

  always_comb begin
    hw_ext                   = '0;
    hw_ext[HW_INT_NUM-1:0]   = hw_int_in;
    tcfg_rd                  = '0;
    tcfg_rd[TIMER_W-1:0]     = tcfg_q;
  end

  csr_timer_int_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .tcfg_we_i    (tcfg_we),
    .tcfg_wdata_i (TIMER_W'(csr_merge(tcfg_rd, csr_wmask, csr_wvalue))),
    .tcfg_o       (tcfg_q),
    .tval_o       (tval),
    .fire_o       (timer_fire)
  );

  always_comb begin
    crmd_d = crmd_q; prmd_d = prmd_q; ecfg_d = ecfg_q; estat_d = estat_q;
    era_d = era_q; badv_d = badv_q; eentry_d = eentry_q; tid_d = tid_q;
    save_d = save_q;
    // Registers also updated by wb_ex/ertn_flush drop a same-cycle software write.
    if (csr_we) begin
      case (csr_num)
        CSR_CRMD:   if (!wb_ex && !ertn_flush) crmd_d = csr_apply(crmd_q, csr_wmask, csr_wvalue, CRMD_RW);
        CSR_PRMD:   if (!wb_ex) prmd_d = csr_apply(prmd_q, csr_wmask, csr_wvalue, PRMD_RW);
        CSR_ECFG:   ecfg_d = csr_apply(ecfg_q, csr_wmask, csr_wvalue, ECFG_RW);
        CSR_ESTAT:  if (!wb_ex) estat_d = csr_apply(estat_q, csr_wmask, csr_wvalue, ESTAT_RW);
        CSR_ERA:    if (!wb_ex) era_d = csr_merge(era_q, csr_wmask, csr_wvalue);
        CSR_BADV:   if (!wb_ex) badv_d = csr_merge(badv_q, csr_wmask, csr_wvalue);
        CSR_EENTRY: eentry_d = csr_apply(eentry_q, csr_wmask, csr_wvalue, EENTRY_RW);
        CSR_TID:    tid_d = csr_merge(tid_q, csr_wmask, csr_wvalue);
        default: ;
      endcase
      for (int i = 0; i < SAVE_NUM; i++) begin
        if (csr_num == CSR_SAVE_BASE + 14'(i)) save_d[i] = csr_merge(save_q[i], csr_wmask, csr_wvalue);
      end
    end
    estat_d[9:2]     = hw_ext;
    estat_d[IS_RSVD] = 1'b0;
    estat_d[IS_TIMER] = timer_fire | (estat_q[IS_TIMER] & ~ticlr_clr);
    estat_d[IS_IPI]  = ipi_int_in;
    if (ertn_flush && !wb_ex) crmd_d[2:0] = prmd_q[2:0];
    if (wb_ex) begin
      prmd_d[2:0] = crmd_q[2:0];
      crmd_d[2:0] = 3'b000;
      era_d       = wb_pc;
      estat_d[ESTAT_ECODE_LSB +: 6] = wb_ecode;
      estat_d[ESTAT_ESUB_LSB +: 9]  = wb_esubcode;
      if (wb_ecode == ECODE_ADEF || wb_ecode == ECODE_ALE) badv_d = wb_vaddr;
    end
    has_int_d = ~wb_ex & crmd_q[CRMD_IE] & (|(estat_q[12:0] & ecfg_q[12:0]));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd_q <= CRMD_RESET; prmd_q <= '0; ecfg_q <= '0; estat_q <= '0;
      era_q <= '0; badv_q <= '0; eentry_q <= '0; tid_q <= CORE_ID;
      has_int_q <= 1'b0;
      for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= '0;
    end else begin
      crmd_q <= crmd_d; prmd_q <= prmd_d; ecfg_q <= ecfg_d; estat_q <= estat_d;
      era_q <= era_d; badv_q <= badv_d; eentry_q <= eentry_d; tid_q <= tid_d;
      has_int_q <= has_int_d;
      save_q <= save_d;
    end
  end

  always_comb begin
    csr_rvalue = '0;
    case (csr_raddr)
      CSR_CRMD:   csr_rvalue = crmd_q;
      CSR_PRMD:   csr_rvalue = prmd_q;
      CSR_ECFG:   csr_rvalue = ecfg_q;
      CSR_ESTAT:  csr_rvalue = estat_q;
      CSR_ERA:    csr_rvalue = era_q;
      CSR_BADV:   csr_rvalue = badv_q;
      CSR_EENTRY: csr_rvalue = eentry_q;
      CSR_TID:    csr_rvalue = tid_q;
      CSR_TCFG:   csr_rvalue = tcfg_rd;
      CSR_TVAL:   csr_rvalue = tval;
      default: ;
    endcase
    for (int i = 0; i < SAVE_NUM; i++) begin
      if (csr_raddr == CSR_SAVE_BASE + 14'(i)) csr_rvalue = save_q[i];
    end
  end

  assign ex_entry = eentry_q;
  assign ex_exit  = era_q;
  assign has_int  = has_int_q;

endmodule

// File: tb/tb_csr_timer_int.sv
// Directed bench for csr_timer_int: register read/write table, then
// hand-written timer, interrupt, exception and reset sequences.
module tb_csr_timer_int;
  import csr_timer_int_pkg::*;

  logic        clk, resetn;
  logic        csr_we;
  logic [13:0] csr_num, csr_raddr;
  logic [31:0] csr_wmask, csr_wvalue, csr_rvalue, ex_entry, ex_exit;
  logic        has_int, ertn_flush, wb_ex, ipi_int_in;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr;
  logic [7:0]  hw_int_in;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  csr_timer_int #(.TIMER_W(32), .HW_INT_NUM(8), .SAVE_NUM(4), .CORE_ID(32'h0000_00a5)) dut (
    .clk(clk), .resetn(resetn), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_raddr(csr_raddr),
    .csr_rvalue(csr_rvalue), .ex_entry(ex_entry), .ex_exit(ex_exit),
    .has_int(has_int), .ertn_flush(ertn_flush), .wb_ex(wb_ex),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .wb_vaddr(wb_vaddr), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drivers: called at a negedge, return at the following negedge
  task automatic csr_wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_we = 1'b1; csr_num = num; csr_wmask = mask; csr_wvalue = val;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] v);
    csr_raddr = a;
    #1;
    v = csr_rvalue;
  endtask

  task automatic chk_csr(input string name, input logic [13:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(name, v, exp);
  endtask

  task automatic chk_is11(input string name, input logic exp);
    logic [31:0] v;
    rd(CSR_ESTAT, v);
    check(name, 32'(v[IS_TIMER]), 32'(exp));
  endtask

  task automatic wait_tval(input logic [31:0] target, input string name);
    logic [31:0] v;
    int n;
    n = 0;
    rd(CSR_TVAL, v);
    while (v != target && n < 60) begin
      @(negedge clk);
      n++;
      rd(CSR_TVAL, v);
    end
    check(name, v, target);
  endtask

  typedef struct {
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] val;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[22];

  initial begin
    logic [31:0] v, e;

    vecs[0]  = '{CSR_CRMD,   32'hffff_ffff, 32'h0000_001f, 32'h0000_001f};
    vecs[1]  = '{CSR_CRMD,   32'hffff_ffff, 32'h0000_0008, 32'h0000_0008};
    vecs[2]  = '{CSR_CRMD,   32'h0000_0003, 32'hffff_ffff, 32'h0000_000b};
    vecs[3]  = '{CSR_CRMD,   32'hffff_ffff, 32'h0000_0008, 32'h0000_0008};
    vecs[4]  = '{CSR_PRMD,   32'hffff_ffff, 32'hffff_ffff, 32'h0000_0007};
    vecs[5]  = '{CSR_PRMD,   32'hffff_ffff, 32'h0000_0000, 32'h0000_0000};
    vecs[6]  = '{CSR_ECFG,   32'hffff_ffff, 32'hffff_ffff, 32'h0000_1bff};
    vecs[7]  = '{CSR_ECFG,   32'hffff_ffff, 32'h0000_0000, 32'h0000_0000};
    vecs[8]  = '{CSR_ESTAT,  32'hffff_ffff, 32'hffff_ffff, 32'h0000_0003};
    vecs[9]  = '{CSR_ESTAT,  32'hffff_ffff, 32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{CSR_ERA,    32'hffff_ffff, 32'h1234_5678, 32'h1234_5678};
    vecs[11] = '{CSR_ERA,    32'hffff_0000, 32'habcd_0000, 32'habcd_5678};
    vecs[12] = '{CSR_BADV,   32'hffff_ffff, 32'hcafe_f00d, 32'hcafe_f00d};
    vecs[13] = '{CSR_EENTRY, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffc0};
    vecs[14] = '{CSR_TID,    32'h0000_00ff, 32'h0000_0055, 32'h0000_0055};
    vecs[15] = '{14'h030,    32'hffff_ffff, 32'h1111_1111, 32'h1111_1111};
    vecs[16] = '{14'h033,    32'hffff_ffff, 32'h3333_3333, 32'h3333_3333};
    vecs[17] = '{14'h034,    32'hffff_ffff, 32'h4444_4444, 32'h0000_0000};
    vecs[18] = '{CSR_TCFG,   32'hffff_ffff, 32'h0000_0012, 32'h0000_0012};
    vecs[19] = '{CSR_TVAL,   32'hffff_ffff, 32'h0000_0005, 32'hffff_ffff};
    vecs[20] = '{CSR_TICLR,  32'hffff_ffff, 32'h0000_0001, 32'h0000_0000};
    vecs[21] = '{14'h100,    32'hffff_ffff, 32'hffff_ffff, 32'h0000_0000};

    resetn = 1'b0; csr_we = 1'b0; csr_num = '0; csr_wmask = '0; csr_wvalue = '0;
    csr_raddr = '0; ertn_flush = 1'b0; wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0;
    wb_pc = '0; wb_vaddr = '0; hw_int_in = '0; ipi_int_in = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Reset values
    chk_csr("rst_crmd",  CSR_CRMD,  32'h0000_0008);
    chk_csr("rst_prmd",  CSR_PRMD,  32'h0);
    chk_csr("rst_ecfg",  CSR_ECFG,  32'h0);
    chk_csr("rst_estat", CSR_ESTAT, 32'h0);
    chk_csr("rst_era",   CSR_ERA,   32'h0);
    chk_csr("rst_tid",   CSR_TID,   32'h0000_00a5);
    chk_csr("rst_tcfg",  CSR_TCFG,  32'h0);
    chk_csr("rst_tval",  CSR_TVAL,  32'hffff_ffff);
    check("rst_has_int", 32'(has_int), 32'h0);
    @(negedge clk);

    // Register table
    for (int i = 0; i < 22; i++) begin
      csr_wr(vecs[i].num, vecs[i].mask, vecs[i].val);
      rd(vecs[i].num, v);
      check($sformatf("vec%0d", i), v, vecs[i].exp);
    end
    check("ex_entry", ex_entry, 32'hffff_ffc0);
    check("ex_exit", ex_exit, 32'habcd_5678);
    chk_csr("save0_hold", 14'h030, 32'h1111_1111);
    @(negedge clk);

    // Hardware / IPI interrupt sampling
    hw_int_in = 8'ha5; ipi_int_in = 1'b1;
    @(negedge clk);
    chk_csr("estat_hw_ipi", CSR_ESTAT, 32'h0000_1294);
    hw_int_in = 8'h00; ipi_int_in = 1'b0;
    @(negedge clk);
    chk_csr("estat_hw_clear", CSR_ESTAT, 32'h0);

    // Periodic timer, InitVal=4: counts 16..0, fires, reloads 16
    csr_wr(CSR_TCFG, 32'hffff_ffff, 32'h0000_0013);
    for (int k = 16; k >= 0; k--) exp_q.push_back(32'(k));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      rd(CSR_TVAL, v);
      check("tval_count", v, e);
      if (e == 32'h0) chk_is11("is11_before_fire", 1'b0);
      @(negedge clk);
    end
    chk_is11("is11_fire", 1'b1);
    chk_csr("tval_reload", CSR_TVAL, 32'd16);
    repeat (16) @(negedge clk);
    chk_csr("tval_period_zero", CSR_TVAL, 32'd0);
    csr_wr(CSR_TICLR, 32'hffff_ffff, 32'h1);
    chk_is11("ticlr_vs_fire", 1'b1);
    chk_csr("tval_reload2", CSR_TVAL, 32'd16);
    csr_wr(CSR_TICLR, 32'hffff_ffff, 32'h1);
    chk_is11("ticlr_clear", 1'b0);
    chk_csr("tval_after_clr", CSR_TVAL, 32'd15);

    // Timer interrupt through ECFG.LIE and CRMD.IE
    csr_wr(CSR_ECFG, 32'hffff_ffff, 32'h0000_0800);
    csr_wr(CSR_CRMD, 32'h0000_0004, 32'h0000_0004);
    wait_tval(32'd0, "wait_fire");
    @(negedge clk);
    chk_is11("is11_int", 1'b1);
    check("has_int_lat0", 32'(has_int), 32'h0);
    @(negedge clk);
    check("has_int_set", 32'(has_int), 32'h1);
    csr_wr(CSR_CRMD, 32'h0000_0004, 32'h0000_0000);
    check("has_int_lag", 32'(has_int), 32'h1);
    @(negedge clk);
    check("has_int_ie0", 32'(has_int), 32'h0);

    // En=0 stops the count where it is
    wait_tval(32'd5, "wait_tval5");
    csr_wr(CSR_TCFG, 32'hffff_ffff, 32'h0);
    chk_csr("tval_hold", CSR_TVAL, 32'd5);
    repeat (3) @(negedge clk);
    chk_csr("tval_hold3", CSR_TVAL, 32'd5);
    csr_wr(CSR_TICLR, 32'hffff_ffff, 32'h1);
    chk_is11("is11_clr2", 1'b0);

    // One-shot InitVal=2: fires once, wraps to all-ones
    csr_wr(CSR_TCFG, 32'hffff_ffff, 32'h0000_0009);
    chk_csr("os_start", CSR_TVAL, 32'd8);
    repeat (8) @(negedge clk);
    chk_csr("os_zero", CSR_TVAL, 32'd0);
    chk_is11("os_is11_pre", 1'b0);
    @(negedge clk);
    chk_csr("os_wrap", CSR_TVAL, 32'hffff_ffff);
    chk_is11("os_fire", 1'b1);
    csr_wr(CSR_TICLR, 32'hffff_ffff, 32'h1);
    chk_is11("os_clr", 1'b0);
    repeat (20) @(negedge clk);
    chk_is11("os_no_refire", 1'b0);
    chk_csr("os_idle_tval", CSR_TVAL, 32'hffff_ffff);

    // Exception entry (ALE) with a colliding ERA write, then ertn
    csr_wr(CSR_CRMD, 32'h0000_0007, 32'h0000_0007);
    chk_csr("crmd_pre_ex", CSR_CRMD, 32'h0000_000f);
    wb_ex = 1'b1; wb_ecode = 6'h09; wb_esubcode = 9'h0;
    wb_pc = 32'h1c00_0100; wb_vaddr = 32'h0000_1003;
    csr_we = 1'b1; csr_num = CSR_ERA; csr_wmask = 32'hffff_ffff; csr_wvalue = 32'hdead_beef;
    @(negedge clk);
    wb_ex = 1'b0; csr_we = 1'b0;
    chk_csr("ex_prmd",  CSR_PRMD,  32'h0000_0007);
    chk_csr("ex_crmd",  CSR_CRMD,  32'h0000_0008);
    chk_csr("ex_badv",  CSR_BADV,  32'h0000_1003);
    chk_csr("ex_era",   CSR_ERA,   32'h1c00_0100);
    chk_csr("ex_estat", CSR_ESTAT, 32'h0009_0000);
    check("ex_exit_port", ex_exit, 32'h1c00_0100);
    ertn_flush = 1'b1;
    @(negedge clk);
    ertn_flush = 1'b0;
    chk_csr("ertn_crmd", CSR_CRMD, 32'h0000_000f);

    // Non-address exception: BADV held, colliding BADV write dropped
    wb_ex = 1'b1; wb_ecode = 6'h0b; wb_esubcode = 9'h001;
    wb_pc = 32'h1c00_0200; wb_vaddr = 32'h0000_5555;
    csr_we = 1'b1; csr_num = CSR_BADV; csr_wmask = 32'hffff_ffff; csr_wvalue = 32'h0000_7777;
    @(negedge clk);
    wb_ex = 1'b0; csr_we = 1'b0;
    chk_csr("ex2_badv",  CSR_BADV,  32'h0000_1003);
    chk_csr("ex2_era",   CSR_ERA,   32'h1c00_0200);
    chk_csr("ex2_estat", CSR_ESTAT, 32'h004b_0000);
    chk_csr("ex2_prmd",  CSR_PRMD,  32'h0000_0007);
    chk_csr("ex2_crmd",  CSR_CRMD,  32'h0000_0008);
    @(negedge clk);

    // Asynchronous reset while the timer runs
    csr_wr(CSR_TCFG, 32'hffff_ffff, 32'h0000_0013);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk_csr("arst_tval",  CSR_TVAL,  32'hffff_ffff);
    chk_csr("arst_crmd",  CSR_CRMD,  32'h0000_0008);
    chk_csr("arst_prmd",  CSR_PRMD,  32'h0);
    chk_csr("arst_era",   CSR_ERA,   32'h0);
    chk_csr("arst_estat", CSR_ESTAT, 32'h0);
    chk_csr("arst_tid",   CSR_TID,   32'h0000_00a5);
    check("arst_has_int", 32'(has_int), 32'h0);
    check("arst_ex_entry", ex_entry, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    chk_csr("post_rst_tval",  CSR_TVAL,  32'hffff_ffff);
    chk_csr("post_rst_estat", CSR_ESTAT, 32'h0);
    chk_csr("post_rst_tcfg",  CSR_TCFG,  32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
